booth4_iter_mul: RTL and testbench
==================================

Name: booth4_iter_mul

Overview:
- Parametrised, iterative, signed radix-4 Booth multiplier for the filter datapath.
- Successor to the fixed 32x11 combinational Booth multiplier. Instead of reducing all partial products in one cycle, it recodes and accumulates one Booth digit per clock.
- Operands are loaded through a valid/ready handshake. The product is returned through a second valid/ready handshake as a scaled, truncated window, with an overflow flag.
- Sits between the coefficient/sample fetch stage and the filter accumulator.

Parameters:
- XW, 32, width of multiplicand x (signed two's complement).
- YW, 11, width of multiplier y (signed two's complement); 2 <= YW <= XW.
- OUT_LSB, 10, index of the full-product bit that maps to p[0].
- OUT_W, 32, output window width; OUT_LSB+OUT_W <= XW+YW.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- x  in  XW  signed multiplicand
- y  in  YW  signed multiplier
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- p  out  OUT_W  product[OUT_LSB+OUT_W-1:OUT_LSB]
- ovf  out  1  discarded product MSBs are not a sign extension of p[OUT_W-1]
- busy  out  1  state != IDLE

Behaviour:
- Full product P = x*y, exact, PW = XW+YW bits signed.
- ND = ceil(YW/2) Booth digits. y is sign-extended to 2*ND bits with an implicit y[-1]=0.
- Digit k uses bits {y[2k+1], y[2k], y[2k-1]} and maps to one of {0, ±x, ±2x}, weighted 4^k.
  - Encoding: one = y0^y1; two = ~one & (y2^y1); neg = y2.
  - Negation is implemented as invert plus a sign-factor LSB add, folded into the accumulator.
- Accumulator holds at least PW+2 bits and is sign-extended throughout. The result must equal the exact product for all operand pairs, including x=-2^(XW-1) and y=-2^(YW-1).
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch x and y, clear the accumulator and digit counter, go to CALC.
  - CALC: in_ready=0. Each edge adds digit k (k = 0..ND-1, LSB digit first) and increments the counter. After the edge that processes digit ND-1, go to DONE.
  - DONE: out_valid=1 and p/ovf are stable. On out_ready, go to IDLE. With out_ready=0, hold indefinitely; p and ovf must not change.
- Latency: operands accepted at edge t, out_valid rises at edge t+ND (6 for defaults). A new operand pair is accepted no earlier than the edge after the output handshake, so throughput is one result per ND+2 cycles minimum.
- p = P[OUT_LSB+OUT_W-1:OUT_LSB], truncation toward minus infinity.
- ovf = 1 iff P[PW-1:OUT_LSB+OUT_W-1] is not all-equal. When OUT_LSB+OUT_W = PW, ovf is tied to 0.
- in_valid is ignored outside IDLE. x and y may change after the accept edge without effect.
- Reset (rst_n=0 at any edge, including mid-CALC or mid-DONE): state=IDLE, p=0, ovf=0, out_valid=0, busy=0, in_ready=1 from the next cycle. The in-flight operation is discarded with no output.
- out_ready while not in DONE has no effect.

Optional Feature:
- Macro: BOOTH4_ITER_ROUND_EN.
- Defined: before windowing, add 2^(OUT_LSB-1) to P, giving round-half-up. ovf is computed on the rounded value. Latency is unchanged; the constant is injected as the accumulator's initial value. If OUT_LSB=0, the rounding add is 0.
- Undefined: plain truncation as specified above.

Test Plan:
- Basic result: x=0x00100000, y=3 -> out_valid 6 edges after accept, p=0x00000C00, ovf=0.
- Negative truncation: x=0xFFFFFFFF (-1), y=1 -> p=0xFFFFFFFF, ovf=0. With BOOTH4_ITER_ROUND_EN -> p=0x00000000.
- Maximum negative multiplier: x=0x7FFFFFFF, y=11'h400 (-1024) -> p=0x80000001, ovf=0.
- Overflow corner: x=0x80000000, y=11'h400 -> P=2^41, p=0x80000000, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> p/ovf stable, in_ready=0, a second in_valid pulse is ignored. Then out_ready=1 for one cycle -> IDLE, and the next pair is accepted.
- Reset mid-operation: assert rst_n=0 during the 3rd CALC cycle -> next cycle out_valid=0, p=0, in_ready=1. A fresh pair (x=5, y=-3, OUT_LSB=0 build) -> p=-15 (0xFFFFFFF1).

Source files
------------

// File: rtl/booth4_iter_mul_if.sv
// booth4_iter_mul_if
//   Operand and result handshake bundle for booth4_iter_mul.
//   Operand side : in_valid/in_ready, x (XW, signed), y (YW, signed)
//   Result side  : out_valid/out_ready, p (OUT_W), ovf
//   master: producer of operands and consumer of results (fetch stage / bench).
//   slave : the multiplier.
interface booth4_iter_mul_if #(
  parameter int XW    = 32,
  parameter int YW    = 11,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] p;
  logic             ovf;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, p, ovf
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, p, ovf
  );
endinterface

// File: rtl/booth4_iter_mul.sv
// booth4_iter_mul
//   Iterative signed radix-4 Booth multiplier. One Booth digit of y is
//   recoded and accumulated per clock (LSB digit first); the exact product
//   P = x*y (XW+YW bits) is returned as the window P[OUT_LSB+OUT_W-1:OUT_LSB]
//   with an overflow flag for the discarded upper bits.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : booth4_iter_mul_if.slave
//              in_valid/in_ready/x/y      operand handshake (accepted in IDLE)
//              out_valid/out_ready/p/ovf  result handshake (held in DONE)
//   busy   : high whenever the block is not idle
//
// Build option
//   BOOTH4_ITER_ROUND_EN : when defined, 2^(OUT_LSB-1) is preloaded into the
//   accumulator so the window rounds half-up instead of truncating.
module booth4_iter_mul #(
  parameter int XW      = 32,
  parameter int YW      = 11,
  parameter int OUT_LSB = 10,
  parameter int OUT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  booth4_iter_mul_if.slave   bus,
  output logic               busy
);

  localparam int PW  = XW + YW;          // exact product width
  localparam int AW  = PW + 2;           // accumulator width (headroom for 2x and negation)
  localparam int ND  = (YW + 1) / 2;     // number of Booth digits
  localparam int YEW = 2 * ND;           // y sign-extended to whole digits
  localparam int CW  = $clog2(ND + 1);   // digit counter width
  localparam int OHI = OUT_LSB + OUT_W - 1;
  localparam int RSH = (OUT_LSB > 0) ? OUT_LSB - 1 : 0;

`ifdef BOOTH4_ITER_ROUND_EN
  localparam logic [AW-1:0] ACC_INIT = (OUT_LSB > 0) ? (AW'(1) << RSH) : '0;
`else
  localparam logic [AW-1:0] ACC_INIT = '0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   acc_q;
  logic [AW-1:0]   mcand_q;   // x * 4^k, advanced by two bits each digit
  logic [YEW:0]    yr_q;      // {y sign-extended, y[-1]=0}, shifted two bits per digit
  logic [CW-1:0]   cnt_q;

  logic            accept;
  logic            last_digit;

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    last_digit = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        last_digit = (cnt_q == CW'(ND - 1));
        if (last_digit) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign busy          = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Booth digit recoding and partial product
  // ---------------------------------------------------------------------------
  logic          b0, b1, b2;
  logic          one, two, neg;
  logic [AW-1:0] pp, addend, acc_sum;

  always_comb begin
    {b2, b1, b0} = yr_q[2:0];
    one    = b0 ^ b1;
    two    = ~one & (b2 ^ b1);
    neg    = b2;
    pp     = '0;
    if (one)      pp = mcand_q;
    else if (two) pp = {mcand_q[AW-2:0], 1'b0};
    // Negation as one's complement plus a carry-in of neg; since pp already
    // carries the 4^k weight, the +1 at bit 0 completes the two's complement.
    // Digit 111 gives ~0 + 1 = 0 modulo 2^AW, as required.
    addend  = neg ? ~pp : pp;
    acc_sum = acc_q + addend + {{(AW-1){1'b0}}, neg};
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      yr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        acc_q   <= ACC_INIT;
        mcand_q <= AW'(signed'(bus.x));
        yr_q    <= {YEW'(signed'(bus.y)), 1'b0};
        cnt_q   <= '0;
      end else if (state_q == CALC) begin
        acc_q   <= acc_sum;
        mcand_q <= mcand_q << 2;
        yr_q    <= yr_q >> 2;
        cnt_q   <= cnt_q + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output window and overflow. acc_q only changes in CALC/accept, so p and
  // ovf are stable throughout DONE; reset clears them to zero.
  // ---------------------------------------------------------------------------
  assign bus.p = acc_q[OHI:OUT_LSB];

  generate
    if (OHI == PW - 1) begin : g_no_ovf
      logic unused_hi;
      assign unused_hi = ^acc_q[AW-1:PW];
      assign bus.ovf   = 1'b0;
    end else begin : g_ovf
      // The accumulator is an exact sign extension of P, so testing the
      // full upper slice is equivalent to testing P[PW-1:OHI].
      logic [AW-1:OHI] top;
      assign top     = acc_q[AW-1:OHI];
      assign bus.ovf = ~((&top) | ~(|top));
    end

    if (OUT_LSB > 0) begin : g_lo
      logic unused_lo;
      assign unused_lo = ^acc_q[OUT_LSB-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_booth4_iter_mul.sv
module tb_booth4_iter_mul;

  localparam int XW      = 32;
  localparam int YW      = 11;
  localparam int OUT_LSB = 10;
  localparam int OUT_W   = 32;
  localparam int ND      = 6;

`ifdef BOOTH4_ITER_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  always #5 clk = ~clk;

  booth4_iter_mul_if #(.XW(XW), .YW(YW), .OUT_W(OUT_W)) bus ();

  booth4_iter_mul #(
    .XW(XW), .YW(YW), .OUT_LSB(OUT_LSB), .OUT_W(OUT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy)
  );

  typedef struct {
    logic [31:0] p;
    logic        ovf;
    int          acc_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   lat_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Monitor: samples 1 time unit after the falling edge, after stimulus drives.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && bus.out_valid) begin
        if (sb.size() == 0) begin
          if (bus.out_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got p=0x%0h, expected no result", bus.p);
          end
        end else begin
          if (!lat_seen) begin
            check({sb[0].name, "_latency"}, 64'(cyc - sb[0].acc_cyc), 64'(ND));
            lat_seen = 1'b1;
          end
          if (bus.out_ready) begin
            check({sb[0].name, "_p"},   bus.p,   sb[0].p);
            check({sb[0].name, "_ovf"}, bus.ovf, sb[0].ovf);
            void'(sb.pop_front());
            lat_seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input string name, input logic [31:0] xv, input logic [10:0] yv,
                      input logic [31:0] ep, input logic eo);
    int w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      fail_now({name, "_accept"});
      return;
    end
    bus.x        = xv;
    bus.y        = yv;
    bus.in_valid = 1'b1;
    sb.push_back('{ep, eo, cyc + 1, name});
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.x        = ~xv;   // operands are latched; later changes must not matter
    bus.y        = ~yv;
  endtask

  task automatic drain(input string name);
    int w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      fail_now({name, "_drain"});
      sb.delete();
    end
  endtask

  initial begin
    int w;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.x        = '0;
    bus.y        = '0;

    repeat (2) @(negedge clk);
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy",      busy,          0);
    check("rst_p",         bus.p,         0);
    check("rst_ovf",       bus.ovf,       0);
    rst_n = 1'b1;

    // Directed vectors, expected values worked by hand (window P[41:10]).
    send("basic",     32'h0010_0000, 11'd3,     32'h0000_0C00, 1'b0);
    send("neg_trunc", 32'hFFFF_FFFF, 11'd1,     RND ? 32'h0 : 32'hFFFF_FFFF, 1'b0);
    send("max_neg_y", 32'h7FFF_FFFF, 11'h400,   32'h8000_0001, 1'b0);
    send("ovf_corner",32'h8000_0000, 11'h400,   32'h8000_0000, 1'b1);
    send("mixed",     32'h1234_5678, 11'h0FF,   32'h0488_8888, 1'b0);
    send("minx_m1",   32'h8000_0000, 11'h7FF,   32'h0020_0000, 1'b0);
    send("zero_x",    32'h0000_0000, 11'h3FF,   32'h0000_0000, 1'b0);
    send("half_neg",  32'h0000_0600, 11'h7FF,   RND ? 32'hFFFF_FFFF : 32'hFFFF_FFFE, 1'b0);
    send("max_pos",   32'h7FFF_FFFF, 11'h3FF,   32'h7FDF_FFFF, 1'b0);
    send("minx_maxy", 32'h8000_0000, 11'h3FF,   32'h8020_0000, 1'b0);
    drain("vectors");

    // Backpressure: result must hold, in_valid must be ignored.
    @(negedge clk);
    bus.out_ready = 1'b0;
    send("bp", 32'h0010_0000, 11'd3, 32'h0000_0C00, 1'b0);
    w = 0;
    while (!bus.out_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.out_valid) fail_now("bp_wait_valid");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) begin
        bus.x        = 32'h0000_0001;
        bus.y        = 11'd1;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      check("bp_hold_p",   bus.p,         32'h0000_0C00);
      check("bp_hold_ovf", bus.ovf,       0);
      check("bp_in_ready", bus.in_ready,  0);
      check("bp_valid",    bus.out_valid, 1);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_back_idle", bus.in_ready, 1);
    send("after_bp", 32'hFFFF_FFFF, 11'd1, RND ? 32'h0 : 32'hFFFF_FFFF, 1'b0);
    drain("bp");

    // Reset in the third CALC cycle: the in-flight result is discarded.
    send("rst_victim", 32'h1234_5678, 11'h0FF, 32'h0488_8888, 1'b0);
    #1;
    check("calc_busy",     busy,         1);
    check("calc_in_ready", bus.in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    void'(sb.pop_back());
    lat_seen = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_p",         bus.p,         0);
    check("midrst_ovf",       bus.ovf,       0);
    check("midrst_in_ready",  bus.in_ready,  1);
    check("midrst_busy",      busy,          0);
    repeat (10) @(negedge clk);
    send("fresh", 32'h0000_0005, 11'h7FD, RND ? 32'h0 : 32'hFFFF_FFFF, 1'b0);
    drain("fresh");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
